pic_config_sequencer: RTL

//  Bus-master sequencer that programs the 8259A-style PIC through its CS/WR/RD/A0/DBus write port.
//  On start it issues the ICW1..ICW4 init sequence and the initial OCW1 mask.

---
 rtl/pic_config_sequencer.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pic_config_sequencer.sv
// Bus-master that programs an 8259A-style PIC: ICW1..ICW4 + OCW1 init, then prioritised runtime OCW writes.
// Optional PIC_CFG_READBACK_EN adds an IRR/ISR readback access (OCW3 write followed by a read cycle).
module pic_config_sequencer #(
    parameter logic [7:0]  ICW1_VAL   = 8'h13,
    parameter logic [7:0]  ICW2_VAL   = 8'h90,
    parameter logic [7:0]  ICW3_VAL   = 8'h00,
    parameter logic [7:0]  ICW4_VAL   = 8'h02,
    parameter logic [7:0]  OCW1_VAL   = 8'h0F,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       eoi_req,
    input  logic [7:0] eoi_val,
    input  logic       mask_req,
    input  logic [7:0] mask_val,
    input  logic       ocw3_req,
    input  logic [7:0] ocw3_val,
`ifdef PIC_CFG_READBACK_EN
    input  logic       rd_req,
    input  logic       rd_isr,
    input  logic [7:0] DBus_in,
    output logic [7:0] rd_data,
    output logic       rd_valid,
`endif
    output logic       eoi_ack,
    output logic       mask_ack,
    output logic       ocw3_ack,
    output logic       busy,
    output logic       init_done,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    output logic       A0,
    output logic [7:0] DBus,
    output logic       DBus_oe
);

    localparam int CW = 8;
    localparam logic HAS_ICW3 = ~ICW1_VAL[1];
    localparam logic HAS_ICW4 = ICW1_VAL[0];
    localparam logic [2:0] INIT_END = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP} state_t;
    typedef enum logic [2:0] {K_INIT, K_EOI, K_MASK, K_OCW3, K_RBW, K_RBR} kind_t;

    state_t        state_q, state_d;
    kind_t         kind_q, kind_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          a0_q, a0_d;
    logic [7:0]    data_q, data_d;
    logic [2:0]    init_idx_q, init_idx_d;
    logic          init_done_q, init_done_d;

    // Init list slots: 0 ICW1, 1 ICW2, 2 ICW3, 3 ICW4, 4 OCW1; optional slots are skipped.
    function automatic logic [2:0] init_next(input logic [2:0] idx);
        case (idx)
            3'd0:    init_next = 3'd1;
            3'd1:    init_next = HAS_ICW3 ? 3'd2 : (HAS_ICW4 ? 3'd3 : 3'd4);
            3'd2:    init_next = HAS_ICW4 ? 3'd3 : 3'd4;
            3'd3:    init_next = 3'd4;
            default: init_next = INIT_END;
        endcase
    endfunction

    function automatic logic [8:0] init_item(input logic [2:0] idx);
        case (idx)
            3'd0:    init_item = {1'b0, ICW1_VAL};
            3'd1:    init_item = {1'b1, ICW2_VAL};
            3'd2:    init_item = {1'b1, ICW3_VAL};
            3'd3:    init_item = {1'b1, ICW4_VAL};
            default: init_item = {1'b1, OCW1_VAL};
        endcase
    endfunction

    logic       rd_req_w;
    logic [7:0] rb_cmd_w;
`ifdef PIC_CFG_READBACK_EN
    assign rd_req_w = rd_req;
    assign rb_cmd_w = rd_isr ? 8'h0B : 8'h0A;
`else
    assign rd_req_w = 1'b0;
    assign rb_cmd_w = 8'h0A;
`endif

    logic       phase_last;
    logic [3:0] excl;
    logic [3:0] elig;
    logic       arb_ok;
    logic       grant_valid;
    kind_t      grant_kind;
    logic       grant_a0;
    logic [7:0] grant_data;

    always_comb begin
        case (state_q)
            S_SETUP:  phase_last = (cnt_q == CW'(SETUP_CYC - 1));
            S_STROBE: phase_last = (cnt_q == CW'(STROBE_CYC - 1));
            S_HOLD:   phase_last = (cnt_q == CW'(HOLD_CYC - 1));
            default:  phase_last = 1'b1;
        endcase
    end

    // In GAP the request just served is masked: its requester may still hold req for that cycle.
    always_comb begin
        excl = 4'b0000;
        if (state_q == S_GAP) begin
            case (kind_q)
                K_EOI:   excl[0] = 1'b1;
                K_MASK:  excl[1] = 1'b1;
                K_OCW3:  excl[2] = 1'b1;
                K_RBR:   excl[3] = 1'b1;
                default: excl = 4'b0000;
            endcase
        end
    end

    assign elig   = {rd_req_w, ocw3_req, mask_req, eoi_req} & ~excl;
    assign arb_ok = init_done_q &&
                    ((state_q == S_IDLE) ||
                     (state_q == S_GAP && kind_q != K_INIT && kind_q != K_RBW));

    always_comb begin
        grant_valid = 1'b1;
        grant_kind  = K_EOI;
        grant_a0    = 1'b0;
        grant_data  = eoi_val;
        if (elig[0]) begin
            grant_kind = K_EOI;
        end else if (elig[1]) begin
            grant_kind = K_MASK;
            grant_a0   = 1'b1;
            grant_data = mask_val;
        end else if (elig[2]) begin
            grant_kind = K_OCW3;
            grant_data = ocw3_val;
        end else if (elig[3]) begin
            grant_kind = K_RBW;
            grant_data = rb_cmd_w;
        end else begin
            grant_valid = 1'b0;
        end
    end

`ifdef PIC_CFG_READBACK_EN
    logic [7:0] rd_data_q, rd_data_d;
`endif

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        cnt_d       = cnt_q;
        a0_d        = a0_q;
        data_d      = data_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
`ifdef PIC_CFG_READBACK_EN
        rd_data_d   = rd_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d        = S_SETUP;
                    kind_d         = K_INIT;
                    init_idx_d     = 3'd0;
                    {a0_d, data_d} = init_item(3'd0);
                    init_done_d    = 1'b0;
                end else if (arb_ok && grant_valid) begin
                    state_d = S_SETUP;
                    kind_d  = grant_kind;
                    a0_d    = grant_a0;
                    data_d  = grant_data;
                end
            end
            S_SETUP: begin
                cnt_d = cnt_q + 1'b1;
                if (phase_last) begin
                    state_d = S_STROBE;
                    cnt_d   = '0;
                end
            end
            S_STROBE: begin
                cnt_d = cnt_q + 1'b1;
                if (phase_last) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
`ifdef PIC_CFG_READBACK_EN
                    if (kind_q == K_RBR) rd_data_d = DBus_in;
`endif
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (phase_last) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
                if (kind_q == K_INIT) begin
                    if (init_next(init_idx_q) == INIT_END) begin
                        init_done_d = 1'b1;
                    end else begin
                        state_d        = S_SETUP;
                        init_idx_d     = init_next(init_idx_q);
                        {a0_d, data_d} = init_item(init_next(init_idx_q));
                    end
                end else if (kind_q == K_RBW) begin
                    state_d = S_SETUP;
                    kind_d  = K_RBR;
                end else if (arb_ok && grant_valid) begin
                    state_d = S_SETUP;
                    kind_d  = grant_kind;
                    a0_d    = grant_a0;
                    data_d  = grant_data;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            kind_q      <= K_INIT;
            cnt_q       <= '0;
            a0_q        <= 1'b0;
            data_q      <= 8'h00;
            init_idx_q  <= 3'd0;
            init_done_q <= 1'b0;
`ifdef PIC_CFG_READBACK_EN
            rd_data_q   <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cnt_q       <= cnt_d;
            a0_q        <= a0_d;
            data_q      <= data_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
`ifdef PIC_CFG_READBACK_EN
            rd_data_q   <= rd_data_d;
`endif
        end
    end

    logic cs_active;
    logic hold_done;
    assign cs_active = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
    assign hold_done = (state_q == S_HOLD) && phase_last;

    assign CS        = ~cs_active;
    assign WR        = ~((state_q == S_STROBE) && (kind_q != K_RBR));
    assign DBus_oe   = cs_active && (kind_q != K_RBR);
    assign DBus      = DBus_oe ? data_q : 8'h00;
    assign A0        = cs_active ? a0_q : 1'b0;
    assign eoi_ack   = hold_done && (kind_q == K_EOI);
    assign mask_ack  = hold_done && (kind_q == K_MASK);
    assign ocw3_ack  = hold_done && (kind_q == K_OCW3);
    assign init_done = init_done_q;
    assign busy      = (state_q != S_IDLE) || start || (arb_ok && grant_valid);

`ifdef PIC_CFG_READBACK_EN
    assign RD       = ~((state_q == S_STROBE) && (kind_q == K_RBR));
    assign rd_data  = rd_data_q;
    assign rd_valid = hold_done && (kind_q == K_RBR);
`else
    assign RD = 1'b1;
`endif

endmodule
